// File: rtl/axi_lite_regfile_controller.sv
// AXI-Lite user-side register bank: round-robin read/write arbitration, one access in flight.
// Define AXI_LITE_REGCTRL_STATUS_EN to add a read-only status word at idx == NUM_REGS.
module axi_lite_regfile_controller #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          awaddr,
    input  logic                                   awvalid,
    output logic                                   awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        wstrb,
    input  logic                                   wvalid,
    output logic                                   wready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          araddr,
    input  logic                                   arvalid,
    output logic                                   arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          rdata,
    output logic                                   rvalid,
    input  logic                                   rready,
`ifdef AXI_LITE_REGCTRL_STATUS_EN
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in,
`endif
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                last_grant_reg, last_grant_next;   // 1: write was granted last
    logic [DW-1:0]       reg_bank_reg [NUM_REGS];
    logic [DW-1:0]       rdata_reg, rdata_next;
    logic [NUM_REGS-1:0] wr_pulse_reg, wr_pulse_next;
    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;
    logic                wreq;
    logic                rreq;

    // Address/data stay valid on the bus until accepted, so WRITE/RD_ADDR decode them live.
    assign wr_idx = awaddr >> ADDR_LSB;
    assign rd_idx = araddr >> ADDR_LSB;
    assign wreq   = awvalid && wvalid;
    assign rreq   = arvalid;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (wreq && (!rreq || !last_grant_reg)) begin
                    state_next      = WRITE;
                    last_grant_next = 1'b1;
                end else if (rreq) begin
                    state_next      = RD_ADDR;
                    last_grant_next = 1'b0;
                end
            end
            WRITE:   state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: if (rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (state_reg)
            WRITE: begin
                awready = 1'b1;
                wready  = 1'b1;
            end
            RD_ADDR: arready = 1'b1;
            RD_DATA: rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read data is captured once in RD_ADDR and then frozen for the whole RD_DATA wait.
    always_comb begin
        rdata_next = rdata_reg;
        if (state_reg == RD_ADDR) begin
            rdata_next = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == AW'(i)) rdata_next = reg_bank_reg[i];
            end
`ifdef AXI_LITE_REGCTRL_STATUS_EN
            if (rd_idx == AW'(NUM_REGS)) rdata_next = status_in;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_pulse_next[gi]   = (state_reg == WRITE) && (wr_idx == AW'(gi));
            assign reg_out[gi*DW +: DW] = reg_bank_reg[gi];
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_reg    <= '0;
            wr_pulse_reg <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_bank_reg[i] <= '0;
            end
        end else begin
            rdata_reg    <= rdata_next;
            wr_pulse_reg <= wr_pulse_next;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_pulse_next[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb[b]) reg_bank_reg[i][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign rdata    = rdata_reg;
    assign wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_axi_lite_regfile_controller.sv
// Self-checking bench for axi_lite_regfile_controller: vector table, read scoreboard, corner sequences.
module tb_axi_lite_regfile_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [AW-1:0]    awaddr;
    logic             awvalid;
    logic             awready;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             wvalid;
    logic             wready;
    logic [AW-1:0]    araddr;
    logic             arvalid;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic             rvalid;
    logic             rready;
`ifdef AXI_LITE_REGCTRL_STATUS_EN
    logic [DW-1:0]    status_in;
`endif
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    axi_lite_regfile_controller #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .awaddr(awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .araddr(araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rvalid(rvalid),
        .rready(rready),
`ifdef AXI_LITE_REGCTRL_STATUS_EN
        .status_in(status_in),
`endif
        .reg_out(reg_out),
        .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          stall;
        logic [3:0]  exp_pulse;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] model [NR];
    logic [31:0] sb [$];
    logic [2:0]  arb_pat [9];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // Every task is entered and left 1 ns after a rising edge with the FSM in IDLE.
    task automatic do_reset();
        ARESET = 1'b1;
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;
        clear_model();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [3:0] ep, input logic [31:0] ed);
        $display("WR addr=%h data=%h strb=%h exp_pulse=%b", a, d, s, ep);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge ACLK);
        chk("wr_c0_awready", awready, 1'b0);
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("wr_c1_aw_w_ready", {awready, wready}, 2'b11);
        chk("wr_c1_pulse", wr_pulse, '0);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < NR; i++) if (ep[i]) model[i] = ed;
        @(negedge ACLK);
        chk("wr_c2_awready", awready, 1'b0);
        chk("wr_c2_pulse", wr_pulse, ep);
        chk("wr_c2_reg_out", reg_out, model_flat());
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("wr_c3_pulse", wr_pulse, '0);
        @(posedge ACLK); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input logic [31:0] exp);
        logic [31:0] e;
        $display("RD addr=%h stall=%0d exp=%h", a, stall, exp);
        araddr = a; arvalid = 1'b1;
        sb.push_back(exp);
        @(negedge ACLK);
        chk("rd_c0_arready", arready, 1'b0);
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("rd_c1_arready_rvalid", {arready, rvalid}, 2'b10);
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        @(negedge ACLK);
        chk("rd_c2_arready_rvalid", {arready, rvalid}, 2'b01);
        for (int k = 0; k < stall; k++) begin
            chk("rd_hold_rvalid", rvalid, 1'b1);
            chk("rd_hold_rdata", rdata, sb[0]);
            @(posedge ACLK); #1; @(negedge ACLK);
        end
        rready = 1'b1;
        chk("rd_accept_rvalid", rvalid, 1'b1);
        if (rvalid) begin
            e = sb.pop_front();
            chk("rd_data", rdata, e);
        end
        @(posedge ACLK); #1;
        rready = 1'b0;
        @(negedge ACLK);
        chk("rd_done_rvalid", rvalid, 1'b0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
`ifdef AXI_LITE_REGCTRL_STATUS_EN
        status_in = 32'hA5A5A5A5;
`endif
        //                 wr    addr          data          strb  stall pulse    expected
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 4'b0010, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 32'h04, 32'h11223344, 4'h5, 0, 4'b0010, 32'hDE22BE44};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 5, 4'b0000, 32'hDE22BE44};
        vecs[3]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, 4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0, 0, 4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 32'h08, 32'h12345678, 4'hF, 0, 4'b0100, 32'h12345678};
        vecs[6]  = '{1'b1, 32'h00, 32'hCAFEF00D, 4'h3, 0, 4'b0001, 32'h0000F00D};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1, 4'b0000, 32'h0000F00D};
        vecs[8]  = '{1'b1, 32'h0E, 32'hA1B2C3D4, 4'hC, 0, 4'b1000, 32'hA1B20000};
        vecs[9]  = '{1'b0, 32'h0F, 32'h0,        4'h0, 2, 4'b0000, 32'hA1B20000};
        vecs[10] = '{1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, 4'b0000, 32'h0};
`ifdef AXI_LITE_REGCTRL_STATUS_EN
        vecs[11] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 4'b0000, 32'hA5A5A5A5};
`else
        vecs[11] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 4'b0000, 32'h0};
`endif
        // {awready, arready, rvalid} per cycle with write and read held together.
        arb_pat[0] = 3'b000; arb_pat[1] = 3'b100; arb_pat[2] = 3'b000;
        arb_pat[3] = 3'b010; arb_pat[4] = 3'b001; arb_pat[5] = 3'b000;
        arb_pat[6] = 3'b100; arb_pat[7] = 3'b000; arb_pat[8] = 3'b010;

        @(posedge ACLK);
        do_reset();
        @(negedge ACLK);
        chk("rst_handshakes", {awready, wready, arready, rvalid}, 4'b0000);
        chk("rst_rdata", rdata, '0);
        chk("rst_reg_out", reg_out, '0);
        chk("rst_wr_pulse", wr_pulse, '0);
        @(posedge ACLK); #1;

        $display("ARB write+read held from reset");
        awaddr = 32'h08; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h00; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge ACLK);
            chk($sformatf("arb_c%0d", c), {awready, arready, rvalid}, arb_pat[c]);
            if (c == 2) chk("arb_c2_pulse", wr_pulse, 4'b0100);
            if (c == 4) chk("arb_c4_rdata", rdata, 32'h0);
            @(posedge ACLK); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge ACLK); #1;
        rready = 1'b0;
        @(posedge ACLK); #1;
        do_reset();

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].exp_pulse, vecs[v].exp_data);
            else            do_read(vecs[v].addr, vecs[v].stall, vecs[v].exp_data);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("PARTNER awvalid without wvalid plus read addr=04");
        awaddr = 32'h08; awvalid = 1'b1; wvalid = 1'b0; araddr = 32'h04; arvalid = 1'b1;
        @(negedge ACLK);
        chk("np_c0", {awready, arready}, 2'b00);
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("np_c1", {awready, arready}, 2'b01);
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        @(negedge ACLK);
        chk("np_c2_rvalid", rvalid, 1'b1);
        chk("np_c2_rdata", rdata, model[1]);
        rready = 1'b1;
        @(posedge ACLK); #1;
        rready = 1'b0;
        @(negedge ACLK);
        chk("np_c3", {awready, rvalid}, 2'b00);
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("np_c4_awready", awready, 1'b0);
        @(posedge ACLK); #1;
        awvalid = 1'b0;

        do_write(32'h00, 32'h12345678, 4'hF, 4'b0001, 32'h12345678);
        $display("RSTRD read addr=00 then reset while in RD_DATA");
        araddr = 32'h00; arvalid = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        @(negedge ACLK);
        chk("rr_rvalid", rvalid, 1'b1);
        chk("rr_rdata", rdata, 32'h12345678);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("rr_hold_rvalid", rvalid, 1'b1);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        clear_model();
        awaddr = 32'h04; wdata = 32'h0F0F0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge ACLK);
        chk("rr_after_rvalid", rvalid, 1'b0);
        chk("rr_after_rdata", rdata, '0);
        chk("rr_after_reg_out", reg_out, '0);
        chk("rr_after_awready", awready, 1'b0);
        @(posedge ACLK); #1; @(negedge ACLK);
        chk("rr_new_awready", awready, 1'b1);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model[1] = 32'h0F0F0F0F;
        @(negedge ACLK);
        chk("rr_new_pulse", wr_pulse, 4'b0010);
        chk("rr_new_reg_out", reg_out, model_flat());
        @(posedge ACLK); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
